// File: rtl/exposure_sequencer_if.sv
// Control/handshake bundle between the exposure sequencer, the camera
// front end and the exposure timer.
interface exposure_sequencer_if;
  logic       init;
  logic       exp_increase;
  logic       exp_decrease;
  logic       ovf5;
  logic [4:0] initial_value;
  logic       start;
  logic       erase;
  logic       expose;
  logic       nre_1;
  logic       nre_2;
  logic       adc;
  logic       busy;
  logic       err;

  modport master (
    output init, exp_increase, exp_decrease, ovf5,
    input  initial_value, start, erase, expose, nre_1, nre_2, adc, busy, err
  );

  modport slave (
    input  init, exp_increase, exp_decrease, ovf5,
    output initial_value, start, erase, expose, nre_1, nre_2, adc, busy, err
  );
endinterface

// File: rtl/exposure_sequencer.sv
// Frame control FSM: erase in IDLE, timed exposure with watchdog,
// then an eight-step two-row readout. All outputs are registered.
module exposure_sequencer #(
  parameter int EXP_MIN        = 2,
  parameter int EXP_MAX        = 30,
  parameter int EXP_DEFAULT    = 2,
  parameter int TIMEOUT_MARGIN = 8
) (
  input logic clk,
  input logic rst,
  exposure_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPOSE  = 2'd1,
    READOUT = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] exp_reg;
  logic [2:0] step;
  logic [5:0] wdog;
  logic [5:0] timeout_at;

  // EXP_MAX + TIMEOUT_MARGIN must stay below 64 for the 6-bit watchdog.
  assign timeout_at        = {1'b0, exp_reg} + 6'(TIMEOUT_MARGIN);
  assign bus.initial_value = exp_reg;

  // Row enables and ADC strobe for a readout step, packed {nre_1, nre_2, adc}.
  function automatic logic [2:0] row_drive(input logic [2:0] s);
    row_drive = 3'b110;
    case (s)
      3'd0, 3'd2: row_drive = 3'b010;
      3'd1:       row_drive = 3'b011;
      3'd4, 3'd6: row_drive = 3'b100;
      3'd5:       row_drive = 3'b101;
      default:    row_drive = 3'b110;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      exp_reg    <= 5'(EXP_DEFAULT);
      step       <= 3'd0;
      wdog       <= 6'd0;
      bus.start  <= 1'b0;
      bus.erase  <= 1'b1;
      bus.expose <= 1'b0;
      bus.nre_1  <= 1'b1;
      bus.nre_2  <= 1'b1;
      bus.adc    <= 1'b0;
      bus.busy   <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      bus.start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.init) begin
            state      <= EXPOSE;
            wdog       <= 6'd0;
            bus.start  <= 1'b1;
            bus.erase  <= 1'b0;
            bus.expose <= 1'b1;
            bus.busy   <= 1'b1;
            bus.err    <= 1'b0;
          end else if (bus.exp_increase && !bus.exp_decrease) begin
            if (exp_reg < 5'(EXP_MAX)) exp_reg <= exp_reg + 5'd1;
          end else if (bus.exp_decrease && !bus.exp_increase) begin
            if (exp_reg > 5'(EXP_MIN)) exp_reg <= exp_reg - 5'd1;
          end
        end

        // A late Ovf5 still wins over a watchdog expiring in the same cycle.
        EXPOSE: begin
          if (bus.ovf5) begin
            state      <= READOUT;
            step       <= 3'd0;
            bus.expose <= 1'b0;
            {bus.nre_1, bus.nre_2, bus.adc} <= row_drive(3'd0);
          end else if (wdog == timeout_at) begin
            state      <= IDLE;
            bus.expose <= 1'b0;
            bus.erase  <= 1'b1;
            bus.busy   <= 1'b0;
            bus.err    <= 1'b1;
          end else begin
            wdog <= wdog + 6'd1;
          end
        end

        READOUT: begin
          if (step == 3'd7) begin
            state     <= IDLE;
            bus.erase <= 1'b1;
            bus.busy  <= 1'b0;
            {bus.nre_1, bus.nre_2, bus.adc} <= 3'b110;
          end else begin
            step <= step + 3'd1;
            {bus.nre_1, bus.nre_2, bus.adc} <= row_drive(step + 3'd1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed bench for exposure_sequencer: a frame-level reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_exposure_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   started = 1'b0;

  exposure_sequencer_if bus ();

  exposure_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [12:0] out_vec;
  assign out_vec = {bus.initial_value, bus.start, bus.erase, bus.expose,
                    bus.nre_1, bus.nre_2, bus.adc, bus.busy, bus.err};

  // Reference model: phase 0 idle, 1 exposing, 2 reading; t counts cycles in the phase.
  int m_phase = 0;
  int m_t     = 0;
  int m_exp   = 2;
  bit m_err   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_t     <= 0;
      m_exp   <= 2;
      m_err   <= 1'b0;
    end else if (m_phase == 0) begin
      if (bus.init) begin
        m_phase <= 1;
        m_t     <= 0;
        m_err   <= 1'b0;
      end else if (bus.exp_increase && !bus.exp_decrease) begin
        m_exp <= (m_exp + 1 > 30) ? 30 : m_exp + 1;
      end else if (bus.exp_decrease && !bus.exp_increase) begin
        m_exp <= (m_exp - 1 < 2) ? 2 : m_exp - 1;
      end
    end else if (m_phase == 1) begin
      if (bus.ovf5) begin
        m_phase <= 2;
        m_t     <= 0;
      end else if (m_t == m_exp + 8) begin
        m_phase <= 0;
        m_err   <= 1'b1;
      end else begin
        m_t <= m_t + 1;
      end
    end else begin
      if (m_t == 7) m_phase <= 0;
      else          m_t     <= m_t + 1;
    end
  end

  function automatic logic [12:0] model_vec();
    logic [4:0] iv;
    logic st, er, ex, n1, n2, ad, bz;
    iv = 5'(m_exp);
    st = (m_phase == 1) && (m_t == 0);
    er = (m_phase == 0);
    ex = (m_phase == 1);
    n1 = !((m_phase == 2) && (m_t < 3));
    n2 = !((m_phase == 2) && (m_t >= 4) && (m_t <= 6));
    ad = (m_phase == 2) && ((m_t % 4) == 1);
    bz = (m_phase != 0);
    model_vec = {iv, st, er, ex, n1, n2, ad, bz, m_err};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (started && !rst) check_output("cycle_vec", 32'(out_vec), 32'(model_vec()));
    end
  end

  int busy_total  = 0;
  int start_total = 0;
  always @(negedge clk) begin
    if (!rst) begin
      busy_total  <= busy_total + (bus.busy ? 1 : 0);
      start_total <= start_total + (bus.start ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic init, input logic inc,
                                input logic dec, input logic ovf);
    bus.init         = init;
    bus.exp_increase = inc;
    bus.exp_decrease = dec;
    bus.ovf5         = ovf;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (bus.busy && n < limit) begin
      tick();
      n++;
    end
    check_output("wait_idle", 32'(bus.busy), 32'd0);
  endtask

  int snap_busy;
  int snap_start;

  initial begin
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    started = 1'b1;
    check_output("reset_vec", 32'(out_vec), 32'(13'b00010_0_1_0_1_1_0_0_0));

    // Frame with Ovf5 in the third exposure cycle.
    snap_busy = busy_total;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("f1_start", 32'({bus.start, bus.expose, bus.erase, bus.busy}), 32'(4'b1101));
    check_output("f1_initial", 32'(bus.initial_value), 32'd2);
    tick();
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("f1_row1", 32'({bus.nre_1, bus.nre_2, bus.adc}), 32'(3'b010));
    wait_idle(20);
    check_output("f1_erase", 32'(bus.erase), 32'd1);
    check_output("f1_busy_cycles", 32'(busy_total - snap_busy), 32'd11);

    // Exposure adjust with saturation at both ends.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    check_output("inc3", 32'(bus.initial_value), 32'd5);
    repeat (40) tick();
    check_output("inc_sat", 32'(bus.initial_value), 32'd30);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (40) tick();
    check_output("dec_sat", 32'(bus.initial_value), 32'd2);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    check_output("both", 32'(bus.initial_value), 32'd5);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("set10", 32'(bus.initial_value), 32'd10);

    // Exposure must not move while a frame is running.
    snap_start = start_total;
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (7) tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("held_initial", 32'(bus.initial_value), 32'd10);
    wait_idle(5);
    check_output("held_idle", 32'(bus.initial_value), 32'd10);
    check_output("start_once", 32'(start_total - snap_start), 32'd1);

    // Watchdog expiry without Ovf5, then Init clears Err.
    snap_busy = busy_total;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(40);
    check_output("wd_err", 32'(bus.err), 32'd1);
    check_output("wd_cycles", 32'(busy_total - snap_busy), 32'd19);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check_output("err_clear", 32'(bus.err), 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(20);

    // Ovf5 arriving exactly at the watchdog limit still reads out.
    snap_busy = busy_total;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (18) tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("edge_readout", 32'({bus.busy, bus.err, bus.nre_1}), 32'(3'b100));
    wait_idle(20);
    check_output("edge_cycles", 32'(busy_total - snap_busy), 32'd27);

    // Asynchronous reset in the middle of readout.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    check_output("step5", 32'({bus.nre_1, bus.nre_2, bus.adc}), 32'(3'b101));
    #2 rst = 1'b1;
    #1;
    check_output("async_rst", 32'({bus.adc, bus.nre_2, bus.erase, bus.busy, bus.initial_value}),
                 32'({4'b0110, 5'd2}));
    tick();
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("post_rst_frame", 32'({bus.start, bus.expose}), 32'(2'b11));
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(20);
    check_output("post_rst_idle", 32'({bus.erase, bus.err, bus.initial_value}), 32'({2'b10, 5'd2}));

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exposure_sequencer.md
Name: exposure_sequencer

Overview:
- Top-level control FSM for the pixel-array camera.
- Holds the programmable exposure time and sequences one frame: erase, then exposure, then two-row readout.
- Drives the exposure timer counter through its load/start interface (Initial, Start) and waits for the timer's Ovf5 done flag.
- Adds a watchdog so that a missing Ovf5 cannot hang the frame.

Parameters:
- EXP_MIN, 2: minimum exposure value (timer ticks).
- EXP_MAX, 30: maximum exposure value; must be ≤ 31 to fit the 5-bit Initial.
- EXP_DEFAULT, 2: exposure value after reset.
- TIMEOUT_MARGIN, 8: extra EXPOSE cycles allowed beyond Initial before the watchdog fires.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Init  in  1  frame request; sampled in IDLE only.
- Exp_increase  in  1  increment exposure by 1 per cycle while high; IDLE only.
- Exp_decrease  in  1  decrement exposure by 1 per cycle while high; IDLE only.
- Ovf5  in  1  timer done flag from the exposure timer counter.
- Initial  out  5  exposure value presented to the timer.
- Start  out  1  one-cycle timer load/start pulse.
- Erase  out  1  pixel erase; high in IDLE.
- Expose  out  1  pixel exposure enable.
- NRE_1  out  1  row-1 read enable, active-low.
- NRE_2  out  1  row-2 read enable, active-low.
- ADC  out  1  ADC conversion strobe.
- Busy  out  1  high whenever state ≠ IDLE.
- Err  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE, exposure register=EXP_DEFAULT, Initial=EXP_DEFAULT;
  - Start=0, Expose=0, Erase=1, NRE_1=1, NRE_2=1, ADC=0, Busy=0, Err=0;
  - readout step counter=0, watchdog counter=0.
  - Reset applies in any state, including mid-EXPOSE and mid-READOUT.
- Initial always equals the exposure register. The register changes only in IDLE, so Initial is stable during EXPOSE.
- IDLE outputs: Erase=1, Expose=0, NRE_1=NRE_2=1, ADC=0.
- IDLE, exposure adjust (priority order):
  - Init=1 → go to EXPOSE next cycle; exposure adjust is ignored that cycle; Err clears to 0.
  - Else Exp_increase=1 and Exp_decrease=1 → no change.
  - Else Exp_increase=1 → +1, saturating at EXP_MAX.
  - Else Exp_decrease=1 → -1, saturating at EXP_MIN.
- EXPOSE outputs: Expose=1, Erase=0, NRE_1=NRE_2=1, ADC=0.
- EXPOSE, timer handshake:
  - Start=1 only in the first EXPOSE cycle (exactly one cycle), then 0.
  - Watchdog counter (6 bits) is 0 in the first EXPOSE cycle and increments every EXPOSE cycle.
- EXPOSE, exit conditions:
  - Ovf5=1 → READOUT next cycle, step=0.
  - Else watchdog == Initial + TIMEOUT_MARGIN → IDLE next cycle, Err=1.
  - Ovf5 and timeout in the same cycle → Ovf5 wins (READOUT, Err unchanged).
- READOUT: Erase=0, Expose=0. The 3-bit step counter advances 0..7, one step per cycle. Outputs per step:
  - step 0: NRE_1=0
  - step 1: NRE_1=0, ADC=1
  - step 2: NRE_1=0
  - step 3: all inactive
  - step 4: NRE_2=0
  - step 5: NRE_2=0, ADC=1
  - step 6: NRE_2=0
  - step 7: all inactive; next cycle IDLE
  - NRE_1 and NRE_2 are never low simultaneously.
- Inputs ignored by state:
  - Ovf5 ignored in IDLE and READOUT.
  - Init, Exp_increase, Exp_decrease ignored in EXPOSE and READOUT; Init held high re-triggers only once back in IDLE.
- Frame length: 1 IDLE cycle with Init, then EXPOSE until Ovf5, then 8 READOUT cycles.
- All outputs are registered or decoded from state/step only; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then Init=1 for 1 cycle:
   - next cycle Expose=1, Erase=0, Start=1 for 1 cycle, Initial=2, Busy=1;
   - drive Ovf5=1 at EXPOSE cycle 3 → READOUT, with NRE_1 low steps 0–2, ADC high at steps 1 and 5, NRE_2 low steps 4–6;
   - IDLE with Erase=1 after 8 READOUT cycles.
2. Exposure adjust in IDLE:
   - Exp_increase high 3 cycles → Initial=5;
   - Exp_increase high 40 cycles → Initial=30 (saturates);
   - Exp_decrease high 40 cycles → Initial=2 (saturates);
   - both high → Initial unchanged.
3. Exposure held during frame: Initial=10, Init, then Exp_increase held during EXPOSE/READOUT → Initial stays 10 and Start pulses once.
4. Watchdog:
   - Initial=10, Init, Ovf5 never asserted → after EXPOSE cycle 18 state returns to IDLE with Err=1;
   - next Init clears Err to 0.
5. Watchdog boundary: Initial=10, Ovf5=1 exactly at watchdog=18 → READOUT entered, Err stays 0.
6. Reset mid-operation:
   - Reset asserted at READOUT step 5 → immediately (no clock) ADC=0, NRE_2=1, Erase=1, Busy=0, Initial=2;
   - after Reset releases, Init starts a normal frame.
